// File: rtl/pri_encoder_seq.sv
// Sequential priority encoder: captures a request vector and streams out the
// index of each set bit, one per accepted transfer, in LSB- or MSB-first order.
module pri_encoder_seq #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             none,
  output logic             busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             none_r, none_n;
  logic [IDX_W-1:0] pick;
  logic             one_hot;
  logic             load, xfer;

  // Last match wins: scan toward the highest-priority end of the vector.
  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (MSB_FIRST) begin
        if (pend[i]) pick = IDX_W'(i);
      end else begin
        if (pend[WIDTH-1-i]) pick = IDX_W'(WIDTH-1-i);
      end
    end
  end

  assign one_hot = (pend != '0) && ((pend & (pend - WIDTH'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend   <= '0;
      none_r <= 1'b0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      none_r <= none_n;
    end
  end

  assign load = in_valid & in_ready;
  assign xfer = out_valid & out_ready;

  // A load on the same edge as the final transfer overrides the return to IDLE.
  always_comb begin
    state_n = state;
    pend_n  = pend;
    none_n  = 1'b0;
    if (xfer) begin
      pend_n = pend & ~(WIDTH'(1) << pick);
      if (out_last) state_n = IDLE;
    end
    if (load) begin
      if (in_vec != '0) begin
        pend_n  = in_vec;
        state_n = SCAN;
      end else begin
        pend_n  = '0;
        state_n = IDLE;
        none_n  = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = (state == SCAN);
    busy      = out_valid;
    out_idx   = out_valid ? pick : '0;
    out_last  = out_valid & one_hot;
    none      = none_r;
    in_ready  = (state == IDLE) | (out_valid & out_ready & out_last);
  end

endmodule

// File: tb/tb_pri_encoder_seq.sv
// Self-checking bench: two encoders (LSB-first and MSB-first) share stimulus;
// expected index streams are queued at load time and popped on each transfer.
module tb_pri_encoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        out_ready;

  logic       in_ready0, out_valid0, out_last0, none0, busy0;
  logic [3:0] out_idx0;
  logic       in_ready1, out_valid1, out_last1, none1, busy1;
  logic [3:0] out_idx1;

  int checks = 0;
  int errors = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  always #5 clk = ~clk;

  pri_encoder_seq #(.WIDTH(16), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .out_idx(out_idx0),
    .out_last(out_last0), .none(none0), .busy(busy0)
  );

  pri_encoder_seq #(.WIDTH(16), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .out_idx(out_idx1),
    .out_last(out_last1), .none(none1), .busy(busy1)
  );

  task automatic push_exp(input logic [15:0] v);
    int cnt;
    int k;
    cnt = $countones(v);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        k++;
        q0.push_back({(k == cnt), 4'(i)});
      end
    end
    k = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        k++;
        q1.push_back({(k == cnt), 4'(i)});
      end
    end
  endtask

  task automatic monitor();
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_ready) begin
        if (out_valid0) begin
          checks++;
          if (q0.size() == 0) begin
            errors++;
            $display("FAIL lsb_unexpected idx=%0d last=%0b required none", out_idx0, out_last0);
          end else begin
            e = q0.pop_front();
            if ({out_last0, out_idx0} !== e) begin
              errors++;
              $display("FAIL lsb_idx got idx=%0d last=%0b required idx=%0d last=%0b",
                       out_idx0, out_last0, e[3:0], e[4]);
            end
          end
        end
        if (out_valid1) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL msb_unexpected idx=%0d last=%0b required none", out_idx1, out_last1);
          end else begin
            e = q1.pop_front();
            if ({out_last1, out_idx1} !== e) begin
              errors++;
              $display("FAIL msb_idx got idx=%0d last=%0b required idx=%0d last=%0b",
                       out_idx1, out_last1, e[3:0], e[4]);
            end
          end
        end
      end
    end
  endtask

  task automatic load(input logic [15:0] v);
    int n;
    n = 0;
    while (!in_ready0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL load_wait in_ready got %b required 1", in_ready0);
    end
    push_exp(v);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_stream(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid cycle %0d got %b/%b required 1/1", name, k, out_valid0, out_valid1);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1} !== 6'b001001) begin
      errors++;
      $display("FAIL %s_done got v/b/r=%b%b%b %b%b%b required 001 001", name,
               out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid0, out_idx0, out_last0, none0, busy0, in_ready0} !== 9'b0_0000_0001 ||
        {out_valid1, out_idx1, out_last1, none1, busy1, in_ready1} !== 9'b0_0000_0001) begin
      errors++;
      $display("FAIL reset got %b_%b_%b_%b_%b_%b required 0_0000_0_0_0_1",
               out_valid0, out_idx0, out_last0, none0, busy0, in_ready0);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    load(16'h8421);
    check_stream(4, "stream8421");
  endtask

  task automatic test_none();
    load(16'h0000);
    @(negedge clk);
    checks++;
    if (none0 !== 1'b1 || none1 !== 1'b1 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL none_pulse got none=%b valid=%b ready=%b required 1 0 1", none0, out_valid0, in_ready0);
    end
    @(negedge clk);
    checks++;
    if (none0 !== 1'b0 || none1 !== 1'b0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL none_clear got none=%b valid=%b ready=%b required 0 0 1", none0, out_valid0, in_ready0);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    load(16'h0006);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid0, out_idx0, out_last0} !== 6'b1_0001_0 ||
          {out_valid1, out_idx1, out_last1} !== 6'b1_0010_0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got %b_%h_%b / %b_%h_%b required 1_1_0 / 1_2_0", k,
                 out_valid0, out_idx0, out_last0, out_valid1, out_idx1, out_last1);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_stream(2, "stall");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    load(16'h0001);
    checks++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b/%b required 1/1", in_ready0, in_ready1);
    end
    push_exp(16'h0300);
    in_valid = 1'b1;
    in_vec   = 16'h0300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_stream(2, "b2b");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    load(16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    checks++;
    if (q0.size() != 13 || q1.size() != 13) begin
      errors++;
      $display("FAIL mid_popped remaining %0d/%0d required 13/13", q0.size(), q1.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1} !== 6'b001001) begin
      errors++;
      $display("FAIL mid_abort got v/b/r=%b%b%b %b%b%b required 001 001",
               out_valid0, busy0, in_ready0, out_valid1, busy1, in_ready1);
    end
    q0.delete();
    q1.delete();
    out_ready = 1'b1;
    load(16'h0010);
    check_stream(1, "fresh");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_stream();
    test_none();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain leftover %0d/%0d required 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_encoder_seq.md
Name: pri_encoder_seq

Overview:
- Parametrised, sequential successor to the 16-to-4 priority encoder.
- Captures a WIDTH-bit request vector and emits the index of every set bit, one per accepted transfer, in priority order.
- Priority direction is selectable: LSB-first (bit 0 highest) or MSB-first.
- Sits between request sources (interrupt lines, arbitration masks) and a single-index consumer; valid/ready on both sides.

Parameters:
- WIDTH, 16, request vector width; legal range 2..256.
- IDX_W, $clog2(WIDTH), index width; derived, do not override.
- MSB_FIRST, 0, 0 = lowest set bit has priority; 1 = highest set bit has priority.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request vector offered.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  request vector; sampled only on in_valid&&in_ready.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  IDX_W  index of the current highest-priority remaining bit.
- out_last  output  1  current index is the final set bit of the vector.
- none  output  1  one-cycle pulse: the accepted vector was all-zero.
- busy  output  1  scan in progress (state SCAN).

Behaviour:
- Registers: state {IDLE, SCAN}, pend[WIDTH-1:0], none_r.
- Reset (rst=1 at an edge): state=IDLE, pend=0, none_r=0. Outputs after reset: out_valid=0, out_idx=0, out_last=0, none=0, busy=0, in_ready=1.
- Reset mid-scan aborts immediately. Remaining bits are discarded; no further out_valid.
- out_valid = (state==SCAN). busy = out_valid.
- out_idx and out_last are combinational from pend.
  - out_idx = lowest set index of pend (MSB_FIRST=0) or highest (MSB_FIRST=1).
  - out_last = (pend has exactly one bit set).
  - When out_valid=0, both read 0.
- in_ready = (state==IDLE) | (state==SCAN & out_ready & out_last). This permits back-to-back vectors with zero bubble.
- Load (in_valid & in_ready):
  - in_vec != 0: pend <= in_vec, state <= SCAN. out_valid is high the cycle after the load edge (latency 1).
  - in_vec == 0: pend <= 0, state <= IDLE, none_r <= 1 for exactly one cycle (none = none_r). No out_valid.
  - If no load occurs, none_r <= 0.
- Transfer (out_valid & out_ready): clear bit out_idx in pend.
  - If out_last and no simultaneous load: state <= IDLE.
  - If out_last and a simultaneous load: the load rules above take effect on the same edge and override the IDLE transition.
- out_valid & !out_ready: pend, out_idx and out_last hold stable; no index is dropped or skipped.
- in_vec changing while in_ready=0 has no effect.
- Index range: every emitted index is < WIDTH. Each set bit of a loaded vector is emitted exactly once and in strict priority order.
- Throughput: with out_ready held at 1, a vector with k set bits produces k consecutive out_valid cycles.

Test Plan:
- Reset then load in_vec=16'h8421, MSB_FIRST=0, out_ready=1 -> out_idx 0,5,10,15 on four consecutive cycles; out_last=1 only on 15; then in_ready=1, busy=0.
- Same vector with MSB_FIRST=1 -> out_idx 15,10,5,0 in that order.
- Load 16'h0000 -> none=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
- Load 16'h0006, out_ready=0 for 3 cycles then 1 -> out_idx=1 held stable for 3 cycles, then 1 and 2 accepted; no skipped or duplicated index.
- Back-to-back handshake: during the last transfer of 16'h0001, present in_vec=16'h0300 with in_valid=1 -> in_ready=1 that cycle; next cycles emit 8 then 9 with no idle gap.
- Load 16'hFFFF, assert rst after 3 indices (0,1,2) -> next cycle out_valid=0, busy=0, in_ready=1; a fresh load of 16'h0010 emits only 4.
